fnv_hash_sequencer: RTL and testbench

//  Sequences the FNV-1a 32-bit hash datapath behind the I2C peripheral: decodes the

---
 rtl/fnv_hash_sequencer.sv | 159 +++++++++++++++
 tb/tb_fnv_hash_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fnv_hash_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fnv_hash_sequencer: FNV-1a command decode, hash update, byte read-out.   |
// | Optional macro FNV_PIPE_EN splits the multiply over two cycles. Rev 1.0  |
// +--------------------------------------------------------------------------+
module fnv_hash_sequencer #(
  parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
  parameter logic [31:0] FNV_PRIME    = 32'h01000193
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic        rx_first,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        txn_end,
  input  logic        rd_start,
  input  logic        rd_req,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        err,
  output logic [31:0] hash_out
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FEED   = 2'd1;
  localparam logic [1:0] HASH   = 2'd2;
  localparam logic [1:0] IGNORE = 2'd3;

  localparam logic [7:0] CMD_RESET = 8'h01;
  localparam logic [7:0] CMD_FEED  = 8'h02;
  localparam logic [7:0] CMD_LOAD  = 8'h03;
  localparam logic [7:0] CMD_CLR   = 8'h04;

  logic [1:0]  state, state_nxt;
  logic [31:0] hash, snapshot, mix;
  logic [1:0]  rd_ptr;
  logic        accept, is_cmd, is_feed, is_load;

  assign accept   = rx_valid && rx_ready;
  assign is_cmd   = accept && rx_first;
  assign is_feed  = accept && !rx_first && (state == FEED);
  assign is_load  = is_cmd && (rx_data == CMD_LOAD);
  assign mix      = hash ^ {24'b0, rx_data};
  assign hash_out = hash;

`ifdef FNV_PIPE_EN
  logic        end_pending;
  logic [15:0] mix_lo;
  logic [31:0] part_lo;
  logic [15:0] part_hi;
  // Upper half of the product only contributes its low 16 bits after the shift.
  assign part_hi = mix_lo * FNV_PRIME[31:16];
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HASH: begin
`ifdef FNV_PIPE_EN
        state_nxt = (txn_end || end_pending) ? IDLE : FEED;
`else
        state_nxt = IDLE;
`endif
      end
      default: begin
        if (is_cmd)
          state_nxt = (rx_data == CMD_FEED) ? FEED : IGNORE;
`ifdef FNV_PIPE_EN
        else if (is_feed)
          state_nxt = HASH;
`endif
        // A byte entering the second multiply stage finishes before IDLE.
        if (txn_end && (state_nxt != HASH))
          state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
`ifdef FNV_PIPE_EN
    rx_ready = (state != HASH);
    busy     = (state == HASH);
`else
    rx_ready = 1'b1;
    busy     = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hash <= OFFSET_BASIS;
`ifdef FNV_PIPE_EN
      mix_lo      <= 16'd0;
      part_lo     <= 32'd0;
      end_pending <= 1'b0;
`endif
    end else begin
      if (is_cmd && (rx_data == CMD_RESET))
        hash <= OFFSET_BASIS;
`ifdef FNV_PIPE_EN
      else if (is_feed) begin
        mix_lo  <= mix[15:0];
        part_lo <= mix * {16'd0, FNV_PRIME[15:0]};
      end else if (state == HASH)
        hash <= part_lo + {part_hi, 16'd0};
      if (state_nxt == HASH && txn_end) end_pending <= 1'b1;
      else if (state == HASH)           end_pending <= 1'b0;
`else
      else if (is_feed)
        hash <= mix * FNV_PRIME;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err      <= 1'b0;
      snapshot <= OFFSET_BASIS;
    end else begin
      if (is_cmd) begin
        if (rx_data == CMD_CLR)
          err <= 1'b0;
        else if (rx_data == 8'h00 || rx_data > CMD_CLR)
          err <= 1'b1;
      end
      if (is_load) snapshot <= hash;
    end
  end

  // LOAD restarts the read pointer even when a byte is served in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= 2'd0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= rd_req;
      if (rd_req) begin
        case (rd_ptr)
          2'd0:    tx_data <= snapshot[31:24];
          2'd1:    tx_data <= snapshot[23:16];
          2'd2:    tx_data <= snapshot[15:8];
          default: tx_data <= snapshot[7:0];
        endcase
      end
      if (is_load || rd_start) rd_ptr <= 2'd0;
      else if (rd_req)         rd_ptr <= rd_ptr + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fnv_hash_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fnv_hash_sequencer: directed vectors with hand-computed FNV-1a values. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fnv_hash_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0, rx_first = 1'b0, txn_end = 1'b0;
  logic        rd_start = 1'b0, rd_req = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready, tx_valid, busy, err;
  logic [7:0]  tx_data;
  logic [31:0] hash_out;

  int checks = 0;
  int errors = 0;

  fnv_hash_sequencer dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_first(rx_first),
    .rx_data(rx_data), .rx_ready(rx_ready), .txn_end(txn_end),
    .rd_start(rd_start), .rd_req(rd_req), .tx_data(tx_data),
    .tx_valid(tx_valid), .busy(busy), .err(err), .hash_out(hash_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic send(input logic [7:0] b, input logic first, input logic fin);
    int n = 0;
    while (!rx_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    rx_valid = 1'b1; rx_first = first; rx_data = b; txn_end = fin;
    @(negedge clk);
    rx_valid = 1'b0; rx_first = 1'b0; txn_end = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
    check(tag, {24'd0, tx_data}, {24'd0, exp});
  endtask

  task automatic start_read();
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] foobar [6];
    foobar = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};

    idle(3);
    reset = 1'b0;
    check("rst_hash", hash_out, 32'h811C9DC5);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, rx_ready}, 32'd1);
    check("rst_txv", {31'd0, tx_valid}, 32'd0);
    check("rst_txd", {24'd0, tx_data}, 32'd0);

    start_read();
    rd("basis0", 8'h81); rd("basis1", 8'h1C); rd("basis2", 8'h9D); rd("basis3", 8'hC5);

    // FNV-1a("a")
    send(8'h01, 1'b1, 1'b0); send(8'h02, 1'b1, 1'b0); send(8'h61, 1'b0, 1'b0);
    send(8'h03, 1'b1, 1'b0);
    check("hash_a", hash_out, 32'hE40C292C);
    start_read();
    rd("a0", 8'hE4); rd("a1", 8'h0C); rd("a2", 8'h29); rd("a3", 8'h2C);

    // FNV-1a("foobar")
    send(8'h01, 1'b1, 1'b0); send(8'h02, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(foobar[i], 1'b0, 1'b0);
`ifdef FNV_PIPE_EN
      check("pipe_ready_low", {31'd0, rx_ready}, 32'd0);
      check("pipe_busy_high", {31'd0, busy}, 32'd1);
`else
      check("ready_held", {31'd0, rx_ready}, 32'd1);
      check("busy_low", {31'd0, busy}, 32'd0);
`endif
    end
    send(8'h03, 1'b1, 1'b0);
    check("hash_foobar", hash_out, 32'hBF9CF968);
    start_read();
    rd("fb0", 8'hBF); rd("fb1", 8'h9C); rd("fb2", 8'hF9); rd("fb3", 8'h68);
    rd("fb_wrap", 8'hBF);

    // Unknown command: sticky error, data ignored
    send(8'h7F, 1'b1, 1'b0);
    check("err_set", {31'd0, err}, 32'd1);
    send(8'h55, 1'b0, 1'b0);
    idle(2);
    check("ignore_hash", hash_out, 32'hBF9CF968);
    send(8'h04, 1'b1, 1'b0);
    check("err_clr", {31'd0, err}, 32'd0);

    // txn_end alongside a FEED byte: hashed, then IDLE drops the next byte
    send(8'h01, 1'b1, 1'b0); send(8'h02, 1'b1, 1'b0);
    send(8'h61, 1'b0, 1'b1);
    idle(2);
    send(8'h62, 1'b0, 1'b0);
    idle(2);
    check("end_hash", hash_out, 32'hE40C292C);

    // LOAD with rd_req: old byte served, then pointer restarts on new snapshot
    start_read();
    rd("pre_load", 8'hBF);
    rx_valid = 1'b1; rx_first = 1'b1; rx_data = 8'h03; rd_req = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_first = 1'b0; rd_req = 1'b0;
    check("load_old_byte", {24'd0, tx_data}, 32'h0000009C);
    rd("load_new0", 8'hE4);
    rd("load_new1", 8'h0C);

    // Reset mid-operation
    send(8'h7F, 1'b1, 1'b0);
    send(8'h02, 1'b1, 1'b0);
    rx_valid = 1'b1; rx_first = 1'b0; rx_data = 8'h61; reset = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; reset = 1'b0;
    check("mid_rst_hash", hash_out, 32'h811C9DC5);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    send(8'h61, 1'b0, 1'b0);
    idle(2);
    check("mid_rst_idle", hash_out, 32'h811C9DC5);
    start_read();
    rd("mid_rst_snap", 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
